wb_cache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller that sits directly upstream of `memory_interface`. It accepts single-word load/store requests from the core, serves hits from a local tag/data array, and on a miss drives the `memory_interface` enable/done handshake. The handshake first writes back a dirty victim line, then fills the requested line. One line equals one 64-bit memory word.

---
 rtl/wb_cache_pkg.sv | 33 +++
 rtl/wb_cache_array.sv | 54 +++++
 rtl/wb_cache_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_wb_cache_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cache_pkg.sv
// Shared definitions for the write-back cache controller: FSM encoding,
// default geometry and the store byte-merge helper.
package wb_cache_pkg;

  localparam int DEF_ADDR_W  = 14;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_INDEX_W = 6;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOOKUP     = 3'd1,
    WB_ISSUE   = 3'd2,
    WB_WAIT    = 3'd3,
    FILL_ISSUE = 3'd4,
    FILL_WAIT  = 3'd5,
    RESP       = 3'd6
  } state_t;

  // Byte k of the result comes from wdata when be[k] is set, else from line.
  function automatic logic [DEF_DATA_W-1:0] merge_bytes(
    input logic [DEF_DATA_W-1:0]   line,
    input logic [DEF_DATA_W-1:0]   wdata,
    input logic [DEF_DATA_W/8-1:0] be
  );
    logic [DEF_DATA_W-1:0] res;
    res = line;
    for (int k = 0; k < DEF_DATA_W / 8; k++) begin
      if (be[k]) res[k*8 +: 8] = wdata[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_cache_array.sv
// Direct-mapped tag/data storage with valid and dirty bits: combinational
// read port, synchronous write port; only valid/dirty are cleared by rst.
module wb_cache_array
  import wb_cache_pkg::*;
#(
  parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_dirty
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [LINES-1:0]  valid_bits;
  logic [LINES-1:0]  dirty_bits;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  // Every write installs a live line, so valid is always set on write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= 1'b1;
      dirty_bits[wr_index] <= wr_dirty;
    end
  end

  assign rd_valid = valid_bits[rd_index];
  assign rd_dirty = dirty_bits[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/wb_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller in front of
// memory_interface. Optional hit/miss counters: define WB_CACHE_STATS_EN.
module wb_cache_ctrl
  import wb_cache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ready,
  output logic                cpu_busy,
  output logic [ADDR_W-1:0]   addr_mem,
  output logic                rd_wrt_mem,
  output logic                enable,
  output logic [DATA_W-1:0]   data_to_mem,
  input  logic [DATA_W-1:0]   data_from_mem,
  input  logic                done,
  output state_t              dbg_state
`ifdef WB_CACHE_STATS_EN
  ,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
`endif
);

  // Handshakes: cpu_req is taken only in an IDLE cycle (cpu_busy low) and
  // answered by exactly one cpu_ready pulse with cpu_rdata valid alongside it.
  // Toward memory, enable pulses once per transaction with addr/rw/data held
  // until a rising edge of done completes it.

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t               state;
  logic                 req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic [DATA_W/8-1:0]  req_be;
  logic [INDEX_W-1:0]   req_index;
  logic [TAG_W-1:0]     req_tag;
  logic                 done_q;
  logic                 done_rise;
  logic                 hit;

  logic                 rd_valid;
  logic                 rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [DATA_W-1:0]    rd_data;
  logic                 wr_en;
  logic [TAG_W-1:0]     wr_tag;
  logic [DATA_W-1:0]    wr_data;
  logic                 wr_dirty;

  assign req_index = req_addr[INDEX_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
  assign done_rise = done & ~done_q;
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign cpu_busy  = (state != IDLE);
  assign dbg_state = state;

  wb_cache_array #(
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W),
    .INDEX_W (INDEX_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (req_index),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data),
    .wr_dirty (wr_dirty)
  );

  // Writeback completion rewrites the victim unchanged just to drop its dirty bit.
  always_comb begin
    wr_en    = 1'b0;
    wr_tag   = req_tag;
    wr_data  = rd_data;
    wr_dirty = 1'b0;
    case (state)
      LOOKUP: if (hit && req_we) begin
        wr_en    = 1'b1;
        wr_data  = merge_bytes(rd_data, req_wdata, req_be);
        wr_dirty = 1'b1;
      end
      WB_WAIT: if (done_rise) begin
        wr_en  = 1'b1;
        wr_tag = rd_tag;
      end
      FILL_WAIT: if (done_rise) begin
        wr_en    = 1'b1;
        wr_data  = req_we ? merge_bytes(data_from_mem, req_wdata, req_be) : data_from_mem;
        wr_dirty = req_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      cpu_ready   <= 1'b0;
      cpu_rdata   <= '0;
      enable      <= 1'b0;
      rd_wrt_mem  <= 1'b1;
      addr_mem    <= '0;
      data_to_mem <= '0;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_be      <= '0;
    end else begin
      done_q    <= done;
      cpu_ready <= 1'b0;
      enable    <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          req_we    <= cpu_we;
          req_addr  <= cpu_addr;
          req_wdata <= cpu_wdata;
          req_be    <= cpu_be;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            if (!req_we) cpu_rdata <= rd_data;
            state <= RESP;
          end else if (rd_valid && rd_dirty) begin
            state <= WB_ISSUE;
          end else begin
            state <= FILL_ISSUE;
          end
        end
        WB_ISSUE: begin
          enable      <= 1'b1;
          rd_wrt_mem  <= 1'b0;
          addr_mem    <= {rd_tag, req_index};
          data_to_mem <= rd_data;
          state       <= WB_WAIT;
        end
        WB_WAIT: if (done_rise) state <= FILL_ISSUE;
        FILL_ISSUE: begin
          enable     <= 1'b1;
          rd_wrt_mem <= 1'b1;
          addr_mem   <= req_addr;
          state      <= FILL_WAIT;
        end
        FILL_WAIT: if (done_rise) begin
          if (!req_we) cpu_rdata <= data_from_mem;
          state <= RESP;
        end
        RESP: begin
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (!hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Bench for wb_cache_ctrl: directed scenarios plus randomized traffic against
// a line-level cache/memory model and a responder standing in for memory_interface.
module tb_wb_cache_ctrl;
  import wb_cache_pkg::*;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;
  localparam int LINES  = 64;
  localparam int TW     = 1 + ADDR_W + DATA_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [63:0] cpu_wdata = '0;
  logic [7:0]  cpu_be = '0;
  logic [63:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_busy;
  logic [13:0] addr_mem;
  logic        rd_wrt_mem;
  logic        enable;
  logic [63:0] data_to_mem;
  logic [63:0] data_from_mem = '0;
  logic        done = 1'b0;
  state_t      dbg_state;
`ifdef WB_CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  wb_cache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_be        (cpu_be),
    .cpu_rdata     (cpu_rdata),
    .cpu_ready     (cpu_ready),
    .cpu_busy      (cpu_busy),
    .addr_mem      (addr_mem),
    .rd_wrt_mem    (rd_wrt_mem),
    .enable        (enable),
    .data_to_mem   (data_to_mem),
    .data_from_mem (data_from_mem),
    .done          (done),
    .dbg_state     (dbg_state)
`ifdef WB_CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0]    mem [0:(1<<ADDR_W)-1];
  logic           m_valid [LINES];
  logic           m_dirty [LINES];
  logic [7:0]     m_tag   [LINES];
  logic [63:0]    m_data  [LINES];
  int             m_hits = 0;
  int             m_misses = 0;
  logic [TW-1:0]  exp_q[$];

  function automatic logic [63:0] apply_be(input logic [63:0] old_line, input logic [63:0] new_data,
                                           input logic [7:0] be);
    logic [63:0] mask = '0;
    for (int k = 0; k < 8; k++) mask[k*8 +: 8] = {8{be[k]}};
    return (old_line & ~mask) | (new_data & mask);
  endfunction

  task automatic predict(input logic we, input logic [13:0] addr, input logic [63:0] wdata,
                         input logic [7:0] be, output logic [63:0] exp_rd, output logic was_hit);
    int         idx;
    logic [7:0] tg;
    idx = int'(addr[5:0]);
    tg  = addr[13:6];
    was_hit = m_valid[idx] && (m_tag[idx] == tg);
    if (was_hit) begin
      m_hits++;
    end else begin
      m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_q.push_back({1'b0, m_tag[idx], 6'(idx), m_data[idx]});
        mem[{m_tag[idx], 6'(idx)}] = m_data[idx];
      end
      exp_q.push_back({1'b1, addr, 64'h0});
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = mem[addr];
    end
    if (we) begin
      m_data[idx]  = apply_be(m_data[idx], wdata, be);
      m_dirty[idx] = 1'b1;
    end
    exp_rd = m_data[idx];
  endtask

  // ---------------- memory responder ----------------
  int          hold_len = 1;
  int          force_lat = 0;
  int          done_left = 0;
  int          n_txn = 0;
  logic        mem_pend = 1'b0;
  logic [63:0] last_wb_data = '0;
  logic [13:0] last_wb_addr = '0;

  initial begin
    logic [TW-1:0] e;
    logic          cap_rw;
    logic [13:0]   cap_addr;
    logic [63:0]   cap_data;
    logic          was_done;
    int            lat_cnt;
    cap_rw = 1'b1; cap_addr = '0; cap_data = '0; lat_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mem_pend  = 1'b0;
        done      = 1'b0;
        done_left = 0;
        lat_cnt   = 0;
      end else begin
        was_done = done;
        if (done_left > 0) begin
          done_left--;
          if (done_left == 0) done = 1'b0;
        end
        if (enable) begin
          n_txn++;
          check_eq("txn_overlap", 64'(mem_pend), 64'd0);
          cap_rw   = rd_wrt_mem;
          cap_addr = addr_mem;
          cap_data = data_to_mem;
          if (!rd_wrt_mem) begin
            last_wb_data = data_to_mem;
            last_wb_addr = addr_mem;
          end
          check_eq("txn_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("txn_rw", 64'(rd_wrt_mem), 64'(e[TW-1]));
            check_eq("txn_addr", 64'(addr_mem), 64'(e[TW-2 -: ADDR_W]));
            if (!e[TW-1]) check_eq("wb_data", data_to_mem, e[63:0]);
          end
          mem_pend = 1'b1;
          lat_cnt  = (force_lat > 0) ? force_lat : $urandom_range(1, 4);
        end else if (mem_pend) begin
          check_eq("hold_addr", 64'(addr_mem), 64'(cap_addr));
          check_eq("hold_rw", 64'(rd_wrt_mem), 64'(cap_rw));
          if (!cap_rw) check_eq("hold_data", data_to_mem, cap_data);
          if (lat_cnt > 0) lat_cnt--;
          if (lat_cnt == 0 && !was_done && !done) begin
            done          = 1'b1;
            data_from_mem = cap_rw ? mem[cap_addr] : {$urandom, $urandom};
            done_left     = hold_len;
            mem_pend      = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic [63:0] last_rdata = '0;

  task automatic do_req(input logic we, input logic [13:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be);
    logic [63:0] exp_rd;
    logic        was_hit;
    int          cyc;
    predict(we, addr, wdata, be, exp_rd, was_hit);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_eq("busy", 64'(cpu_busy), 64'd1);
      if (!cpu_ready) begin
        cpu_req   = 1'($urandom);
        cpu_we    = 1'($urandom);
        cpu_addr  = 14'($urandom);
        cpu_wdata = {$urandom, $urandom};
        cpu_be    = 8'($urandom);
      end
    end while (!cpu_ready && cyc < 300);
    cpu_req = 1'b0;
    check_eq("ready_seen", 64'(cpu_ready), 64'd1);
    if (cpu_ready) begin
      if (was_hit) check_eq("hit_latency", 64'(cyc), 64'd3);
      if (!we) check_eq("rdata", cpu_rdata, exp_rd);
      check_eq("busy_at_ready", 64'(cpu_busy), 64'd0);
      check_eq("txn_left", 64'(exp_q.size()), 64'd0);
      check_eq("early_done", 64'(mem_pend), 64'd0);
      last_rdata = cpu_rdata;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] exp_rd;
    logic        was_hit;
    int          cyc;
    int          txn_before;
    logic [7:0]  rt;
    logic [5:0]  ri;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {$urandom, $urandom};
    mem[14'h0005] = 64'h0123456789abcdef;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end

    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(cpu_ready), 64'd0);
    check_eq("rst_busy", 64'(cpu_busy), 64'd0);
    check_eq("rst_enable", 64'(enable), 64'd0);
    check_eq("rst_rd_wrt", 64'(rd_wrt_mem), 64'd1);
    check_eq("rst_addr_mem", 64'(addr_mem), 64'd0);
    check_eq("rst_data_to_mem", data_to_mem, 64'd0);
    check_eq("rst_rdata", cpu_rdata, 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;

    // cold load, repeat hit, partial store, readback
    do_req(1'b0, 14'h0005, 64'h0, 8'h00);
    check_eq("tp_cold_load", last_rdata, 64'h0123456789abcdef);
    txn_before = n_txn;
    do_req(1'b0, 14'h0005, 64'h0, 8'h00);
    check_eq("tp_hit_data", last_rdata, 64'h0123456789abcdef);
    do_req(1'b1, 14'h0005, 64'hffffffffffffffff, 8'h0f);
    do_req(1'b0, 14'h0005, 64'h0, 8'h00);
    check_eq("tp_merge", last_rdata, 64'h01234567ffffffff);
    check_eq("tp_no_traffic", 64'(n_txn - txn_before), 64'd0);

    // dirty eviction with done held high across the writeback
    hold_len = 6;
    txn_before = n_txn;
    do_req(1'b0, 14'h0045, 64'h0, 8'h00);
    hold_len = 1;
    check_eq("tp_wb_addr", 64'(last_wb_addr), 64'h0005);
    check_eq("tp_wb_data", last_wb_data, 64'h01234567ffffffff);
    check_eq("tp_evict_txns", 64'(n_txn - txn_before), 64'd2);

    // reset while waiting for a fill
    predict(1'b0, 14'h0085, 64'h0, 8'h00, exp_rd, was_hit);
    force_lat = 30;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0085;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    cyc = 0;
    while (dbg_state != FILL_WAIT && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reach_fill_wait", 64'(dbg_state), 64'(FILL_WAIT));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_state", 64'(dbg_state), 64'(IDLE));
    check_eq("midrst_enable", 64'(enable), 64'd0);
    check_eq("midrst_busy", 64'(cpu_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    force_lat = 0;
    exp_q.delete();
    m_hits = 0;
    m_misses = 0;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
    end
    txn_before = n_txn;
    do_req(1'b0, 14'h0005, 64'h0, 8'h00);
    check_eq("tp_miss_after_rst", 64'(n_txn - txn_before), 64'd1);

    // randomized traffic over a few tags and indices, back-to-back
    for (int n = 0; n < 250; n++) begin
      rt = 8'($urandom_range(0, 3));
      ri = 6'($urandom_range(0, 7));
      hold_len = ($urandom_range(0, 3) == 0) ? 3 : 1;
      do_req(1'($urandom), {rt, ri}, {$urandom, $urandom}, 8'($urandom));
    end
    hold_len = 1;

`ifdef WB_CACHE_STATS_EN
    @(negedge clk);
    check_eq("hit_count", 64'(hit_count), 64'((m_hits > 65535) ? 65535 : m_hits));
    check_eq("miss_count", 64'(miss_count), 64'((m_misses > 65535) ? 65535 : m_misses));
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
